cache_fill_arbiter: RTL and testbench

Fill controller for the prefetching cache. It owns the single backing-memory read port and shares it between two requesters: demand misses from the cache lookup and next-block prefetch requests. Demand misses have strict priority. Prefetches are buffered in a small de-duplicating queue and issued only when no demand miss is waiting. Returned data goes back to the cache as a tagged fill.

---
 rtl/cache_fill_arbiter_if.sv | 34 +++
 rtl/cache_fill_arbiter.sv | 116 +++++++++++
 tb/tb_cache_fill_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_arbiter_if.sv
// Request/fill bus of the cache fill arbiter: demand misses, prefetch hints,
// the backing-memory read port and the fill return path.
interface cache_fill_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  miss_valid;
    logic                  miss_ready;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic                  pf_valid;
    logic [ADDR_WIDTH-1:0] pf_addr;
    logic                  pf_drop;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  fill_valid;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  fill_prefetch;

    // master = cache/memory environment, slave = the arbiter
    modport master (
        output miss_valid, miss_addr, pf_valid, pf_addr, mem_ready, mem_rvalid, mem_rdata,
        input  miss_ready, pf_drop, mem_req, mem_addr,
               fill_valid, fill_addr, fill_data, fill_prefetch
    );
    modport slave (
        input  miss_valid, miss_addr, pf_valid, pf_addr, mem_ready, mem_rvalid, mem_rdata,
        output miss_ready, pf_drop, mem_req, mem_addr,
               fill_valid, fill_addr, fill_data, fill_prefetch
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Shares one backing-memory read port between demand misses (strict priority)
// and a de-duplicating prefetch FIFO; one transaction in flight at a time.
module cache_fill_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int PFQ_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    cache_fill_arbiter_if.slave        bus,
    output logic                       busy,
    output logic [$clog2(PFQ_DEPTH):0] pfq_count
);
    localparam int PW = $clog2(PFQ_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t                                 state;
    logic [ADDR_WIDTH-1:0]                  cur_addr;
    logic                                   cur_pf;
    logic [DATA_WIDTH-1:0]                  rdata;
    logic                                   mem_req;
    logic                                   fill_valid;
    logic                                   pf_drop;
    logic [PFQ_DEPTH-1:0][ADDR_WIDTH-1:0]   q;
    logic [PW-1:0]                          rd_ptr, wr_ptr;
    logic [PW:0]                            count;
    logic [PFQ_DEPTH-1:0]                   ent_hit;
    logic                                   q_full, pop, dup, drop, push;

    // An entry is live when its distance from the head is below the count.
    for (genvar i = 0; i < PFQ_DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off        = PW'(i) - rd_ptr;
        assign ent_hit[i] = ({1'b0, off} < count) && (q[i] == bus.pf_addr);
    end

    assign q_full = (count == (PW+1)'(PFQ_DEPTH));
    assign pop    = (state == IDLE) && !bus.miss_valid && (count != '0);
    // Head being popped still counts as a duplicate: compare is pre-pop.
    assign dup    = (|ent_hit) || (busy && (bus.pf_addr == cur_addr));
    assign drop   = bus.pf_valid && ((q_full && !pop) || dup);
    assign push   = bus.pf_valid && !drop;

    assign bus.miss_ready    = reset && (state == IDLE);
    assign bus.mem_req       = mem_req;
    assign bus.mem_addr      = cur_addr;
    assign bus.fill_valid    = fill_valid;
    assign bus.fill_addr     = cur_addr;
    assign bus.fill_data     = rdata;
    assign bus.fill_prefetch = cur_pf;
    assign bus.pf_drop       = pf_drop;
    assign pfq_count         = count;

    always_ff @(posedge clk) begin
        if (reset && push) q[wr_ptr] <= bus.pf_addr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            cur_pf     <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            fill_valid <= 1'b0;
            busy       <= 1'b0;
            pf_drop    <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            pf_drop <= drop;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);

            case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        cur_addr <= bus.miss_addr;
                        cur_pf   <= 1'b0;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end else if (count != '0) begin
                        cur_addr <= q[rd_ptr];
                        cur_pf   <= 1'b1;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        rdata      <= bus.mem_rdata;
                        fill_valid <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    fill_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench: expected fills are queued as stimulus is driven and
// compared in order as the arbiter returns them; a small memory model answers reads.
module tb_cache_fill_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic [2:0] pfq_count;

    cache_fill_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    cache_fill_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PFQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .pfq_count(pfq_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [31:0] d; logic p; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    // memory model knobs and manual override
    logic        mem_en = 1'b0, rdy_rand = 1'b0;
    int          lat = 0;
    logic        m_ready = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        man_ready = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        pend = 1'b0;
    logic [7:0]  paddr = '0;
    int          wt = 0;

    assign bus.mem_ready  = mem_en ? m_ready  : man_ready;
    assign bus.mem_rvalid = mem_en ? m_rvalid : man_rvalid;
    assign bus.mem_rdata  = mem_en ? m_rdata  : man_rdata;

    function automatic logic [31:0] dfun(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, a + 8'd1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic expect_fill(input logic [7:0] a, input logic [31:0] d, input logic p);
        exp_t e;
        e.a = a; e.d = d; e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic demand(input logic [7:0] a);
        int n = 0;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a;
        while (!bus.miss_ready && n < 200) begin tick(); n++; end
        chk("miss_rdy", bus.miss_ready, 1);
        tick();
        bus.miss_valid = 1'b0;
    endtask

    task automatic pf(input logic [7:0] a, input logic drop_exp, input string tag);
        bus.pf_valid = 1'b1;
        bus.pf_addr  = a;
        tick();
        bus.pf_valid = 1'b0;
        chk(tag, bus.pf_drop, drop_exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin tick(); n++; end
        chk("idle", busy, 0);
    endtask

    // memory: random/fixed ready, read data lat cycles after the handshake
    initial begin
        forever begin
            @(negedge clk);
            m_rvalid = 1'b0;
            if (!mem_en) begin
                pend = 1'b0; m_ready = 1'b0;
            end else begin
                if (pend) begin
                    if (wt == 0) begin
                        m_rvalid = 1'b1; m_rdata = dfun(paddr); pend = 1'b0;
                    end else wt--;
                end
                m_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (bus.mem_req && m_ready && !pend) begin
                    pend = 1'b1; paddr = bus.mem_addr; wt = lat;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.fill_valid) begin
            if (exp_q.size() == 0) chk("fill_unexp", bus.fill_valid, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("fill_addr", bus.fill_addr, mon_e.a);
                chk("fill_data", bus.fill_data, mon_e.d);
                chk("fill_pf",   bus.fill_prefetch, mon_e.p);
            end
        end
    end

    initial begin
        int n;
        bus.miss_valid = 1'b0; bus.miss_addr = '0;
        bus.pf_valid = 1'b0;   bus.pf_addr = '0;

        // reset state
        repeat (3) tick();
        chk("rst_mreq",  bus.mem_req, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_cnt",   pfq_count, 0);
        chk("rst_fill",  bus.fill_valid, 0);
        chk("rst_drop",  bus.pf_drop, 0);
        chk("rst_mrdy",  bus.miss_ready, 0);
        chk("rst_faddr", bus.fill_addr, 0);
        reset = 1'b1;
        tick();

        // single demand miss, memory answers immediately
        man_ready = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hDEADBEEF;
        expect_fill(8'h10, 32'hDEADBEEF, 1'b0);
        bus.miss_valid = 1'b1; bus.miss_addr = 8'h10;
        chk("s_mrdy", bus.miss_ready, 1);
        tick();
        bus.miss_valid = 1'b0;
        chk("s_mreq1", bus.mem_req, 1);
        chk("s_maddr", bus.mem_addr, 8'h10);
        chk("s_mrdy0", bus.miss_ready, 0);
        tick();
        chk("s_mreq2", bus.mem_req, 0);
        chk("s_fv2", bus.fill_valid, 0);
        tick();
        chk("s_fv3", bus.fill_valid, 1);
        chk("s_fa3", bus.fill_addr, 8'h10);
        chk("s_fd3", bus.fill_data, 32'hDEADBEEF);
        chk("s_fp3", bus.fill_prefetch, 0);
        tick();
        chk("s_busy4", busy, 0);
        chk("s_fv4", bus.fill_valid, 0);
        man_ready = 1'b0; man_rvalid = 1'b0;
        mem_en = 1'b1;

        // priority: demand waiting beats queued prefetches
        lat = 2; rdy_rand = 1'b0;
        expect_fill(8'h50, dfun(8'h50), 1'b0);
        expect_fill(8'h20, dfun(8'h20), 1'b0);
        expect_fill(8'h14, dfun(8'h14), 1'b1);
        expect_fill(8'h18, dfun(8'h18), 1'b1);
        demand(8'h50);
        pf(8'h14, 1'b0, "pr_d14");
        pf(8'h18, 1'b0, "pr_d18");
        chk("pr_cnt", pfq_count, 2);
        demand(8'h20);
        wait_idle();
        chk("pr_cnt0", pfq_count, 0);

        // queue full, then wrap
        lat = 8; rdy_rand = 1'b1;
        expect_fill(8'h60, dfun(8'h60), 1'b0);
        for (int i = 1; i <= 4; i++) expect_fill(8'(i), dfun(8'(i)), 1'b1);
        demand(8'h60);
        for (int i = 1; i <= 4; i++) pf(8'(i), 1'b0, "fu_push");
        chk("fu_cnt4", pfq_count, 4);
        pf(8'h05, 1'b1, "fu_drop5");
        chk("fu_cnt4b", pfq_count, 4);
        wait_idle();
        expect_fill(8'h70, dfun(8'h70), 1'b0);
        for (int i = 6; i <= 9; i++) expect_fill(8'(i), dfun(8'(i)), 1'b1);
        demand(8'h70);
        for (int i = 6; i <= 9; i++) pf(8'(i), 1'b0, "wr_push");
        wait_idle();
        chk("wr_cnt0", pfq_count, 0);

        // de-duplication against queue and in-flight address
        lat = 8; rdy_rand = 1'b0;
        expect_fill(8'h40, dfun(8'h40), 1'b0);
        expect_fill(8'h30, dfun(8'h30), 1'b1);
        demand(8'h40);
        pf(8'h30, 1'b0, "dd_first");
        pf(8'h30, 1'b1, "dd_dup");
        chk("dd_inwait", bus.mem_req, 0);
        pf(8'h40, 1'b1, "dd_cur");
        chk("dd_cnt", pfq_count, 1);
        wait_idle();

        // push and pop in the same IDLE cycle with a full queue
        expect_fill(8'h90, dfun(8'h90), 1'b0);
        for (int i = 0; i <= 4; i++) expect_fill(8'hA0 + 8'(i), dfun(8'hA0 + 8'(i)), 1'b1);
        demand(8'h90);
        for (int i = 0; i < 4; i++) pf(8'hA0 + 8'(i), 1'b0, "pp_push");
        chk("pp_cnt4", pfq_count, 4);
        n = 0;
        while (!bus.fill_valid && n < 100) begin tick(); n++; end
        chk("pp_fill", bus.fill_valid, 1);
        tick();
        chk("pp_idle", busy, 0);
        pf(8'hA4, 1'b0, "pp_nodrop");
        chk("pp_cnt", pfq_count, 4);
        wait_idle();

        // reset in WAIT abandons the transaction
        mem_en = 1'b0; man_ready = 1'b1; man_rvalid = 1'b0;
        demand(8'hB0);
        pf(8'hC0, 1'b0, "rm_push");
        chk("rm_busy", busy, 1);
        chk("rm_wait", bus.mem_req, 0);
        chk("rm_cnt1", pfq_count, 1);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h12345678;
        tick();
        man_rvalid = 1'b0;
        chk("rm_fill", bus.fill_valid, 0);
        chk("rm_busy0", busy, 0);
        chk("rm_cnt0", pfq_count, 0);
        chk("rm_mreq", bus.mem_req, 0);
        tick();
        chk("rm_fill2", bus.fill_valid, 0);
        chk("rm_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
